// File: rtl/typeracer_pkg.sv
// Shared typeracer definitions: game state encodings, tracker phases, datapath widths
// and the words-per-minute saturation helper.
package typeracer_pkg;

    localparam int VALUE_W     = 7;
    localparam int SEC_W       = 8;
    localparam int WPM_W       = 8;
    localparam int SEC_PER_MIN = 60;
    localparam int DIVIDEND_W  = 13;
    localparam int DIVISOR_W   = 8;

    typedef enum logic [1:0] {
        GS_SELECT = 2'd0,
        GS_INGAME = 2'd1,
        GS_FINISH = 2'd2
    } game_state_e;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_RUN  = 2'd1,
        PH_CALC = 2'd2,
        PH_DONE = 2'd3
    } tracker_phase_e;

    // Any quotient bit above the result width means the score overflowed the display.
    function automatic logic [WPM_W-1:0] sat_wpm(input logic [DIVIDEND_W-1:0] q);
        if (|q[DIVIDEND_W-1:WPM_W]) begin
            return '1;
        end
        return q[WPM_W-1:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, start/done handshake.
// Only built when GAME_TRACKER_WPM_EN is defined.
`ifdef GAME_TRACKER_WPM_EN
module seq_divider
    import typeracer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [3:0]            cnt_q;
    logic                  busy_q;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;
    logic                  take;

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        trial = {rem_q, quo_q[DIVIDEND_W-1]};
        take  = (trial >= {1'b0, dsr_q});
        diff  = trial[DIVISOR_W-1:0] - dsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo_q  <= dividend;
                rem_q  <= '0;
                dsr_q  <= divisor;
                cnt_q  <= 4'(DIVIDEND_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= take ? diff : trial[DIVISOR_W-1:0];
                quo_q <= {quo_q[DIVIDEND_W-2:0], take};
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule
`endif

// File: rtl/game_tracker.sv
// Round tracker: seconds/words counting, end-of-round finish pulse and WPM result.
// GAME_TRACKER_WPM_EN enables the sequential WPM divider; otherwise wpm stays 0.
module game_tracker
    import typeracer_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         state,
    input  logic               mode,
    input  logic [VALUE_W-1:0] value,
    input  logic               word_done,
    output logic               finish,
    output logic [VALUE_W-1:0] remaining,
    output logic [SEC_W-1:0]   elapsed,
    output logic [VALUE_W-1:0] words,
    output logic [WPM_W-1:0]   wpm,
    output logic               wpm_valid,
    output tracker_phase_e     phase
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    tracker_phase_e     phase_q, phase_d;
    logic               mode_q;
    logic [VALUE_W-1:0] target_q;
    logic [PRE_W-1:0]   presc_q;
    logic [SEC_W-1:0]   elapsed_q, elapsed_nxt;
    logic [VALUE_W-1:0] words_q, words_nxt, rem_q, rem_nxt;
    logic [WPM_W-1:0]   wpm_q, calc_wpm;
    logic               finish_q, wpm_valid_q;
    logic               tick, end_hit, abort, calc_ready;
    logic               enter, end_round, calc_done, run_active;

    assign abort = (state == GS_SELECT);
    assign tick  = (presc_q == PRE_W'(CLK_HZ - 1));

    // Word mode compares the word count, time mode the whole-second count.
    assign end_hit = mode_q ? (words_q == target_q)
                            : (elapsed_q == {1'b0, target_q});

`ifdef GAME_TRACKER_WPM_EN
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quotient;
    logic                  div_done;

    // Counters are frozen on the end-of-round cycle, so the divider loads alongside finish.
    assign dividend = DIVIDEND_W'(words_q) * DIVIDEND_W'(SEC_PER_MIN);
    assign divisor  = (elapsed_q == '0) ? DIVISOR_W'(1) : elapsed_q;

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (end_round),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .done     (div_done)
    );

    assign calc_ready = div_done;
    assign calc_wpm   = sat_wpm(quotient);
`else
    assign calc_ready = 1'b1;
    assign calc_wpm   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        enter     = 1'b0;
        end_round = 1'b0;
        calc_done = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if (state == GS_INGAME) begin
                    phase_d = PH_RUN;
                    enter   = 1'b1;
                end
            end
            PH_RUN: begin
                if (abort) begin
                    phase_d = PH_IDLE;
                end else if (end_hit) begin
                    phase_d   = PH_CALC;
                    end_round = 1'b1;
                end
            end
            PH_CALC: begin
                if (abort) begin
                    phase_d = PH_IDLE;
                end else if (calc_ready) begin
                    phase_d   = PH_DONE;
                    calc_done = 1'b1;
                end
            end
            PH_DONE: begin
                if (abort) begin
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    assign run_active = (phase_q == PH_RUN) && !abort && !end_hit;

    always_comb begin
        words_nxt   = words_q + VALUE_W'(word_done && (words_q != '1));
        elapsed_nxt = elapsed_q + SEC_W'(tick && (elapsed_q != '1));
        rem_nxt     = mode_q ? (target_q - words_nxt)
                             : (target_q - elapsed_nxt[VALUE_W-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 1'b0;
            target_q    <= '0;
            presc_q     <= '0;
            elapsed_q   <= '0;
            words_q     <= '0;
            rem_q       <= '0;
            wpm_q       <= '0;
            finish_q    <= 1'b0;
            wpm_valid_q <= 1'b0;
        end else begin
            finish_q <= end_round;
            if (enter) begin
                mode_q      <= mode;
                target_q    <= value;
                presc_q     <= '0;
                elapsed_q   <= '0;
                words_q     <= '0;
                rem_q       <= value;
                wpm_q       <= '0;
                wpm_valid_q <= 1'b0;
            end else if (run_active) begin
                presc_q   <= tick ? '0 : presc_q + PRE_W'(1);
                elapsed_q <= elapsed_nxt;
                words_q   <= words_nxt;
                rem_q     <= rem_nxt;
            end
            if (calc_done) begin
                wpm_q       <= calc_wpm;
                wpm_valid_q <= 1'b1;
            end
        end
    end

    assign finish    = finish_q;
    assign remaining = rem_q;
    assign elapsed   = elapsed_q;
    assign words     = words_q;
    assign wpm       = wpm_q;
    assign wpm_valid = wpm_valid_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_game_tracker.sv
// Directed bench for game_tracker at CLK_HZ=10; honours GAME_TRACKER_WPM_EN for
// the expected wpm value and finish-to-valid latency.
module tb_game_tracker;
    import typeracer_pkg::*;

    localparam int CLK_HZ = 10;
`ifdef GAME_TRACKER_WPM_EN
    localparam int CALC_LAT = 14;
    localparam bit WPM_ON   = 1'b1;
`else
    localparam int CALC_LAT = 1;
    localparam bit WPM_ON   = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     state;
    logic           mode;
    logic [6:0]     value;
    logic           word_done;
    logic           finish;
    logic [6:0]     remaining;
    logic [7:0]     elapsed;
    logic [6:0]     words;
    logic [7:0]     wpm;
    logic           wpm_valid;
    tracker_phase_e phase;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    logic [7:0] exp_q[$];

    game_tracker #(.CLK_HZ(CLK_HZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .mode      (mode),
        .value     (value),
        .word_done (word_done),
        .finish    (finish),
        .remaining (remaining),
        .elapsed   (elapsed),
        .words     (words),
        .wpm       (wpm),
        .wpm_valid (wpm_valid),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic wd);
        word_done = wd;
        @(posedge clk);
        #1;
        word_done = 1'b0;
        n++;
    endtask

    task automatic enter_round(input logic m, input logic [6:0] v);
        mode  = m;
        value = v;
        state = GS_INGAME;
        n     = -1;
        cycle(1'b0);
    endtask

    // Runs one full round; word_done is pulsed on the listed cycles (-1 = unused).
    task automatic run_round(input string tag, input logic m, input logic [6:0] v,
                             input int w0, input int w1, input int w2, input int w3,
                             input int exp_fin, input logic [6:0] exp_words,
                             input logic [7:0] exp_elapsed, input logic [7:0] exp_wpm);
        int fin_n   = -1;
        int fin_cnt = 0;
        int val_n   = -1;
        exp_q.push_back(WPM_ON ? exp_wpm : 8'd0);
        enter_round(m, v);
        check({tag, "_rem_entry"}, remaining, v);
        check({tag, "_words_entry"}, words, 0);
        for (int k = 1; k <= 200 && val_n < 0; k++) begin
            cycle(k == w0 || k == w1 || k == w2 || k == w3);
            if (finish) begin
                fin_cnt++;
                if (fin_n < 0) begin
                    fin_n = k;
                    check({tag, "_rem_fin"}, remaining, 0);
                    check({tag, "_words_fin"}, words, exp_words);
                    check({tag, "_elapsed_fin"}, elapsed, exp_elapsed);
                    state = GS_FINISH;
                end
            end
            if (wpm_valid && val_n < 0) val_n = k;
        end
        check({tag, "_fin_cycle"}, fin_n, exp_fin);
        check({tag, "_fin_count"}, fin_cnt, 1);
        check({tag, "_valid_cycle"}, val_n, exp_fin + CALC_LAT);
        check({tag, "_wpm"}, wpm, exp_q.pop_front());
        state = GS_SELECT;
        cycle(1'b0);
        check({tag, "_phase_back"}, phase, PH_IDLE);
        check({tag, "_valid_held"}, wpm_valid, 1);
    endtask

    initial begin
        int fin_seen;
        rst       = 1'b1;
        state     = GS_SELECT;
        mode      = 1'b0;
        value     = '0;
        word_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_finish", finish, 0);
        check("rst_remaining", remaining, 0);
        check("rst_elapsed", elapsed, 0);
        check("rst_words", words, 0);
        check("rst_wpm", wpm, 0);
        check("rst_valid", wpm_valid, 0);
        check("rst_phase", phase, PH_IDLE);
        rst = 1'b0;
        cycle(1'b0);

        //        tag        m     v  word_done cycles     fin words el  wpm
        run_round("time",   1'b0, 3,  3,  7, 12, 18,       31, 4,    3,  80);
        run_round("word",   1'b1, 2,  5, 25, -1, -1,       26, 2,    2,  60);
        run_round("subsec", 1'b1, 1,  3, -1, -1, -1,        4, 1,    0,  60);
        run_round("tie",    1'b0, 2,  4,  9, 20, -1,       21, 3,    2,  90);
        run_round("zero",   1'b0, 0, -1, -1, -1, -1,        1, 0,    0,   0);

        // Abort mid-RUN: no finish, counters held, stray words ignored while idle.
        fin_seen = 0;
        enter_round(1'b0, 7'd5);
        check("abort_valid_clr", wpm_valid, 0);
        for (int k = 1; k <= 15; k++) begin
            cycle(k == 2 || k == 4);
            if (finish) fin_seen++;
            if (k == 10) check("abort_rem_mid", remaining, 4);
        end
        state = GS_SELECT;
        cycle(1'b0);
        if (finish) fin_seen++;
        check("abort_phase", phase, PH_IDLE);
        check("abort_elapsed", elapsed, 1);
        check("abort_words", words, 2);
        check("abort_valid", wpm_valid, 0);
        cycle(1'b1);
        check("abort_idle_word", words, 2);
        check("abort_no_finish", fin_seen, 0);
        enter_round(1'b1, 7'd3);
        check("reentry_words", words, 0);
        check("reentry_elapsed", elapsed, 0);
        check("reentry_rem", remaining, 3);
        cycle(1'b1);
        check("reentry_word_rem", remaining, 2);
        state = GS_SELECT;
        cycle(1'b0);

        // Reset asserted while the result is being computed.
        enter_round(1'b0, 7'd1);
        for (int k = 1; k <= 11; k++) cycle(k == 2);
        check("calc_finish", finish, 1);
        check("calc_phase", phase, PH_CALC);
        rst = 1'b1;
        #1;
        check("arst_finish", finish, 0);
        check("arst_remaining", remaining, 0);
        check("arst_elapsed", elapsed, 0);
        check("arst_words", words, 0);
        check("arst_wpm", wpm, 0);
        check("arst_valid", wpm_valid, 0);
        check("arst_phase", phase, PH_IDLE);
        rst   = 1'b0;
        state = GS_SELECT;
        cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
